// File: rtl/deal_shuffler_pkg.sv
// Shared constants, card encoding helpers and FSM state type for deal_shuffler.
package deal_shuffler_pkg;

    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;

    localparam int CARD_W        = 7;
    localparam int FACE_UP       = 0;
    localparam int DECK_SIZE     = 52;
    localparam int TABLEAU_DEPTH = 19;
    localparam int STOCK_DEPTH   = 24;
    localparam int TABLEAU_CARDS = 28;
    localparam int NUM_TABLEAUS  = 7;

    localparam logic [1:0] CLUBS    = 2'd0;
    localparam logic [1:0] SPADES   = 2'd1;
    localparam logic [1:0] HEARTS   = 2'd2;
    localparam logic [1:0] DIAMONDS = 2'd3;

    typedef logic [CARD_W-1:0] card_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SHUFFLE,
        S_DEAL,
        S_STOCK,
        S_DONE
    } state_t;

    // Ordered-deck card for position n: rank cycles 1..13, suit steps every 13 cards.
    function automatic card_t init_card(input int n);
        logic [1:0] suit;
        case (n / 13)
            0:       suit = CLUBS;
            1:       suit = SPADES;
            2:       suit = HEARTS;
            default: suit = DIAMONDS;
        endcase
        return {4'((n % 13) + 1), suit, 1'b0};
    endfunction

endpackage

// File: rtl/deal_shuffler_card_lfsr.sv
// 16-bit Galois LFSR: loadable, steps on request, exposes current and next value.
module card_lfsr
    import deal_shuffler_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        step,
    output logic [15:0] value,
    output logic [15:0] next_value
);

    assign next_value = (value >> 1) ^ (value[0] ? LFSR_TAPS : 16'h0000);

    // LFSR register: load has priority over stepping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= DEFAULT_SEED;
        end else if (load) begin
            value <= load_value;
        end else if (step) begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/deal_shuffler.sv
// Builds, Fisher-Yates shuffles and deals a Klondike layout, one card per clock.
module deal_shuffler
    import deal_shuffler_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [15:0]                       seed,
    output logic                              busy,
    output logic                              done,
    output logic [DECK_SIZE*CARD_W-1:0]       deck,
    output logic [STOCK_DEPTH*CARD_W-1:0]     stock_pile,
    output logic [TABLEAU_DEPTH*CARD_W-1:0]   tableau1,
    output logic [TABLEAU_DEPTH*CARD_W-1:0]   tableau2,
    output logic [TABLEAU_DEPTH*CARD_W-1:0]   tableau3,
    output logic [TABLEAU_DEPTH*CARD_W-1:0]   tableau4,
    output logic [TABLEAU_DEPTH*CARD_W-1:0]   tableau5,
    output logic [TABLEAU_DEPTH*CARD_W-1:0]   tableau6,
    output logic [TABLEAU_DEPTH*CARD_W-1:0]   tableau7
);

    state_t      state, state_next;
    card_t       deck_mem  [DECK_SIZE];
    card_t       stock_mem [STOCK_DEPTH];
    card_t       tab_mem   [NUM_TABLEAUS][TABLEAU_DEPTH];

    logic [5:0]  i_idx;      // Fisher-Yates upper index
    logic [5:0]  p_idx;      // deck read pointer for deal and stock
    logic [4:0]  r_idx;      // deal round == tableau slot
    logic [2:0]  t_idx;      // tableau number 1..7
    logic [5:0]  j_idx;
    logic        draw_ok;
    logic [4:0]  stock_slot;
    card_t       deal_card;

    logic [15:0] lfsr_value, lfsr_next;
    logic        unused_lfsr_bits;

    card_lfsr u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .load       (state == S_IDLE && start),
        .load_value ((seed == 16'h0000) ? DEFAULT_SEED : seed),
        .step       (state == S_SHUFFLE),
        .value      (lfsr_value),
        .next_value (lfsr_next)
    );

    assign unused_lfsr_bits = ^{lfsr_value, lfsr_next[15:6]};

    // Draw from the freshly stepped LFSR value; unsigned compare rejects j > i.
    assign j_idx      = lfsr_next[5:0];
    assign draw_ok    = (j_idx <= i_idx);
    assign stock_slot = 5'(p_idx - 6'(TABLEAU_CARDS));

    // Card being dealt: only the first card of each round's pile lands face-up.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        deal_card          = deck_mem[p_idx];
        deal_card[FACE_UP] = ({2'b00, t_idx} == (r_idx + 5'd1));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_INIT;
            S_INIT:    state_next = S_SHUFFLE;
            S_SHUFFLE: if (draw_ok && i_idx == 6'd1) state_next = S_DEAL;
            S_DEAL:    if (p_idx == 6'(TABLEAU_CARDS - 1)) state_next = S_STOCK;
            S_STOCK:   if (p_idx == 6'(DECK_SIZE - 1)) state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // FSM outputs, decoded purely from state.
    always_comb begin
        busy = (state == S_INIT) || (state == S_SHUFFLE) ||
               (state == S_DEAL) || (state == S_STOCK);
        done = (state == S_DONE);
    end

    // Deck, pile storage and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: these arrays are architecturally visible outputs that must read zero
            // after reset, so they are flops with reset rather than an inferred RAM.
            for (int n = 0; n < DECK_SIZE; n++) deck_mem[n] <= '0;
            for (int k = 0; k < STOCK_DEPTH; k++) stock_mem[k] <= '0;
            for (int t = 0; t < NUM_TABLEAUS; t++)
                for (int s = 0; s < TABLEAU_DEPTH; s++) tab_mem[t][s] <= '0;
            i_idx <= '0;
            p_idx <= '0;
            r_idx <= '0;
            t_idx <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    for (int n = 0; n < DECK_SIZE; n++) deck_mem[n] <= init_card(n);
                    for (int k = 0; k < STOCK_DEPTH; k++) stock_mem[k] <= '0;
                    for (int t = 0; t < NUM_TABLEAUS; t++)
                        for (int s = 0; s < TABLEAU_DEPTH; s++) tab_mem[t][s] <= '0;
                    i_idx <= 6'(DECK_SIZE - 1);
                    p_idx <= '0;
                    r_idx <= '0;
                    t_idx <= 3'd1;
                end
                S_SHUFFLE: begin
                    if (draw_ok) begin
                        // NOTE: non-blocking reads see pre-edge values, so the two writes
                        // form a true swap and j == i leaves the card in place.
                        deck_mem[i_idx] <= deck_mem[j_idx];
                        deck_mem[j_idx] <= deck_mem[i_idx];
                        i_idx           <= i_idx - 6'd1;
                    end
                end
                S_DEAL: begin
                    tab_mem[3'(t_idx - 3'd1)][r_idx] <= deal_card;
                    p_idx <= p_idx + 6'd1;
                    if (t_idx == 3'd7) begin
                        r_idx <= r_idx + 5'd1;
                        t_idx <= 3'(r_idx + 5'd2);
                    end else begin
                        t_idx <= t_idx + 3'd1;
                    end
                end
                S_STOCK: begin
                    stock_mem[stock_slot] <= {deck_mem[p_idx][CARD_W-1:1], 1'b0};
                    p_idx <= p_idx + 6'd1;
                end
                default: ;
            endcase
        end
    end

    // Flatten storage arrays onto the packed output buses.
    for (genvar n = 0; n < DECK_SIZE; n++) begin : g_deck
        assign deck[n*CARD_W +: CARD_W] = deck_mem[n];
    end

    for (genvar k = 0; k < STOCK_DEPTH; k++) begin : g_stock
        assign stock_pile[k*CARD_W +: CARD_W] = stock_mem[k];
    end

    for (genvar s = 0; s < TABLEAU_DEPTH; s++) begin : g_tab
        assign tableau1[s*CARD_W +: CARD_W] = tab_mem[0][s];
        assign tableau2[s*CARD_W +: CARD_W] = tab_mem[1][s];
        assign tableau3[s*CARD_W +: CARD_W] = tab_mem[2][s];
        assign tableau4[s*CARD_W +: CARD_W] = tab_mem[3][s];
        assign tableau5[s*CARD_W +: CARD_W] = tab_mem[4][s];
        assign tableau6[s*CARD_W +: CARD_W] = tab_mem[5][s];
        assign tableau7[s*CARD_W +: CARD_W] = tab_mem[6][s];
    end

endmodule

// File: tb/tb_deal_shuffler.sv
// Self-checking bench for deal_shuffler: reference shuffle/deal model feeds a scoreboard.
module tb_deal_shuffler;

    localparam int DW = 52 * 7;
    localparam int TW = 19 * 7;
    localparam int SW = 24 * 7;
    localparam int TIMEOUT = 4000;

    typedef struct packed {
        logic [DW-1:0]   deck;
        logic [7*TW-1:0] tab;
        logic [SW-1:0]   stock;
        logic [31:0]     latency;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [15:0]     seed;
    logic            busy, done;
    logic [DW-1:0]   deck;
    logic [SW-1:0]   stock_pile;
    logic [TW-1:0]   tableau1, tableau2, tableau3, tableau4, tableau5, tableau6, tableau7;

    exp_t            sb[$];
    int              n_tests = 0;
    int              n_fail  = 0;

    logic [DW-1:0]   got_deck;
    logic [7*TW-1:0] got_tab;
    logic [SW-1:0]   got_stock;
    int              got_lat;
    int              got_done_pulses;

    deal_shuffler dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seed       (seed),
        .busy       (busy),
        .done       (done),
        .deck       (deck),
        .stock_pile (stock_pile),
        .tableau1   (tableau1),
        .tableau2   (tableau2),
        .tableau3   (tableau3),
        .tableau4   (tableau4),
        .tableau5   (tableau5),
        .tableau6   (tableau6),
        .tableau7   (tableau7)
    );

    always #5 clk = ~clk;

    function automatic logic [7*TW-1:0] all_tabs();
        return {tableau7, tableau6, tableau5, tableau4, tableau3, tableau2, tableau1};
    endfunction

    // Reference model: ordered deck, LFSR-driven Fisher-Yates, Klondike deal, stock.
    task automatic build_expected(input logic [15:0] sd, output exp_t e);
        logic [6:0]  d[52];
        logic [6:0]  tmp;
        logic [15:0] l;
        int          i, j, s, p;
        l = (sd == 16'h0000) ? 16'hACE1 : sd;
        for (int n = 0; n < 52; n++) d[n] = {4'((n % 13) + 1), 2'(n / 13), 1'b0};
        i = 51;
        s = 0;
        while (i > 0 && s < 100000) begin
            s++;
            l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
            j = int'(l[5:0]);
            if (j <= i) begin
                tmp  = d[i];
                d[i] = d[j];
                d[j] = tmp;
                i--;
            end
        end
        e = '0;
        for (int n = 0; n < 52; n++) e.deck[n*7 +: 7] = d[n];
        p = 0;
        for (int r = 0; r < 7; r++) begin
            for (int t = r + 1; t <= 7; t++) begin
                e.tab[((t - 1) * 19 + r) * 7 +: 7] = {d[p][6:1], (t == r + 1)};
                p++;
            end
        end
        for (int k = 0; k < 24; k++) e.stock[k*7 +: 7] = {d[28 + k][6:1], 1'b0};
        e.latency = 32'(1 + s + 28 + 24 + 1);
    endtask

    // One full run from the current negedge: push expectation, pulse start, wait for done,
    // pop and compare; optionally re-pulse start while shuffling.
    task automatic run_and_check(input logic [15:0] sd, input bit poke);
        exp_t e, want;
        int   cnt;
        build_expected(sd, e);
        sb.push_back(e);
        seed  = sd;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt   = 1;
        got_done_pulses = 0;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_rise: busy=%b, want 1 in first cycle after start", busy);
        end
        while (done !== 1'b1 && cnt < TIMEOUT) begin
            @(negedge clk);
            cnt++;
            start = (poke && cnt == 10);
        end
        start   = 1'b0;
        got_lat = cnt;
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_timeout: no done after %0d cycles, want done", cnt);
        end else begin
            got_done_pulses = 1;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_at_done: busy=%b, want 0", busy);
            end
        end
        got_deck  = deck;
        got_tab   = all_tabs();
        got_stock = stock_pile;

        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: size=0, want 1");
        end else begin
            want = sb.pop_front();
            if (got_deck !== want.deck) begin
                n_fail++;
                $display("FAIL deck: got %h want %h", got_deck, want.deck);
            end
            for (int t = 0; t < 7; t++) begin
                n_tests++;
                if (got_tab[t*TW +: TW] !== want.tab[t*TW +: TW]) begin
                    n_fail++;
                    $display("FAIL tableau%0d: got %h want %h", t + 1,
                             got_tab[t*TW +: TW], want.tab[t*TW +: TW]);
                end
            end
            n_tests++;
            if (got_stock !== want.stock) begin
                n_fail++;
                $display("FAIL stock: got %h want %h", got_stock, want.stock);
            end
            n_tests++;
            if (got_lat != int'(want.latency)) begin
                n_fail++;
                $display("FAIL latency: got %0d want %0d", got_lat, want.latency);
            end
        end

        // Idle afterwards: no second done, busy low, outputs held.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done === 1'b1) got_done_pulses++;
        end
        n_tests++;
        if (got_done_pulses != 1) begin
            n_fail++;
            $display("FAIL done_pulses: got %0d want 1", got_done_pulses);
        end
        n_tests++;
        if (busy !== 1'b0 || deck !== got_deck || all_tabs() !== got_tab || stock_pile !== got_stock) begin
            n_fail++;
            $display("FAIL idle_hold: busy=%b outputs_changed=%b, want busy 0 and stable outputs",
                     busy, (deck !== got_deck) || (all_tabs() !== got_tab) || (stock_pile !== got_stock));
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || deck !== '0 || stock_pile !== '0 || all_tabs() !== '0) begin
            n_fail++;
            $display("FAIL %s: busy=%b done=%b deck_nz=%b stock_nz=%b tab_nz=%b, want all 0",
                     tag, busy, done, |deck, |stock_pile, |all_tabs());
        end
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b0;
        seed  = 16'h0000;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst = 1'b1;
        @(negedge clk);
        // Start a run, then pull reset asynchronously mid-shuffle.
        seed  = 16'h1234;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_all_zero("reset_midrun");
        @(negedge clk);
        check_all_zero("reset_held");
        rst = 1'b1;
        // Start in the very cycle after release must be accepted.
        run_and_check(16'h0BAD, 1'b0);
    endtask

    task automatic test_permutation();
        int seen[16][4];
        int tab_cnt, face_cnt;
        logic [6:0] c;
        run_and_check(16'h1234, 1'b0);
        for (int r = 0; r < 16; r++) for (int s = 0; s < 4; s++) seen[r][s] = 0;
        for (int n = 0; n < 52; n++) begin
            c = got_deck[n*7 +: 7];
            seen[c[6:3]][c[2:1]]++;
        end
        for (int r = 1; r <= 13; r++) begin
            for (int s = 0; s < 4; s++) begin
                n_tests++;
                if (seen[r][s] != 1) begin
                    n_fail++;
                    $display("FAIL perm rank%0d suit%0d: got %0d copies want 1", r, s, seen[r][s]);
                end
            end
        end
        // Layout structure, re-derived from the observed deck.
        for (int t = 1; t <= 7; t++) begin
            tab_cnt  = 0;
            face_cnt = 0;
            for (int s = 0; s < 19; s++) begin
                c = got_tab[(t - 1) * TW + s * 7 +: 7];
                if (c != 7'd0) tab_cnt++;
                if (c[0] && s != t - 1) face_cnt++;
                if (!c[0] && s == t - 1) face_cnt++;
            end
            n_tests++;
            if (tab_cnt != t || face_cnt != 0) begin
                n_fail++;
                $display("FAIL layout_t%0d: cards=%0d bad_face=%0d, want cards=%0d bad_face=0",
                         t, tab_cnt, face_cnt, t);
            end
        end
        n_tests++;
        if (tableau1[6:0] !== (got_deck[6:0] | 7'd1) ||
            tableau7[6*7 +: 7] !== (got_deck[27*7 +: 7] | 7'd1) ||
            tableau2[6:0] !== got_deck[1*7 +: 7]) begin
            n_fail++;
            $display("FAIL layout_anchor: t1s0=%h t7s6=%h t2s0=%h want %h %h %h",
                     tableau1[6:0], tableau7[6*7 +: 7], tableau2[6:0],
                     got_deck[6:0] | 7'd1, got_deck[27*7 +: 7] | 7'd1, got_deck[1*7 +: 7]);
        end
        n_tests++;
        if (stock_pile !== got_deck[DW-1 -: SW]) begin
            n_fail++;
            $display("FAIL stock_from_deck: got %h want %h", stock_pile, got_deck[DW-1 -: SW]);
        end
    endtask

    task automatic test_determinism();
        logic [DW-1:0]   a_deck;
        logic [7*TW-1:0] a_tab;
        logic [SW-1:0]   a_stock;
        int              a_lat;
        run_and_check(16'h1234, 1'b0);
        a_deck = got_deck; a_tab = got_tab; a_stock = got_stock; a_lat = got_lat;
        run_and_check(16'h1234, 1'b0);
        n_tests++;
        if (got_deck !== a_deck || got_tab !== a_tab || got_stock !== a_stock || got_lat != a_lat) begin
            n_fail++;
            $display("FAIL repeat_1234: lat %0d vs %0d, outputs_equal=%b, want identical",
                     got_lat, a_lat, (got_deck === a_deck) && (got_tab === a_tab) && (got_stock === a_stock));
        end
        run_and_check(16'h0000, 1'b0);
        a_deck = got_deck; a_tab = got_tab; a_stock = got_stock; a_lat = got_lat;
        run_and_check(16'hACE1, 1'b0);
        n_tests++;
        if (got_deck !== a_deck || got_tab !== a_tab || got_stock !== a_stock || got_lat != a_lat) begin
            n_fail++;
            $display("FAIL seed0_vs_ace1: lat %0d vs %0d, outputs_equal=%b, want identical",
                     got_lat, a_lat, (got_deck === a_deck) && (got_tab === a_tab) && (got_stock === a_stock));
        end
    endtask

    task automatic test_busy_ignore();
        run_and_check(16'h1234, 1'b1);
        run_and_check(16'h5A5A, 1'b1);
    endtask

    initial begin
        test_reset();
        test_permutation();
        test_determinism();
        test_busy_ignore();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/deal_shuffler.md
Name: deal_shuffler

Overview:
- Upstream stage of moveCard: builds an ordered 52-card deck, shuffles it in place (Fisher-Yates driven by a 16-bit LFSR), then deals a Klondike layout.
- Outputs (shuffled deck, seven tableau piles, stock pile) are the initial-state inputs consumed by moveCard.
- Emits one card per clock during dealing; outputs hold until the next start.

Parameters:
- DEFAULT_SEED, 16'hACE1, LFSR seed substituted when seed input is 0.
- LFSR_TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin shuffle+deal; sampled only in IDLE.
- seed  in  16  LFSR seed, captured on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when layout is complete.
- deck  out  52*7  shuffled deck; slot n at bits [7n+6:7n].
- stock_pile  out  24*7  slot 0 = bottom; slot 23 = top.
- tableau1..tableau7  out  19*7 each  slot 0 = bottom; unused slots 7'b0.

Behaviour:
- Card code: [6:3] rank 1..13, [2:1] suit (package constants), [0] face-up. 7'b0 = empty slot.
- Reset (async, rst low): state IDLE; busy=0, done=0; deck, stock_pile, tableau1..7 all zero; LFSR=DEFAULT_SEED; all counters 0.
- IDLE: start=1 -> INIT and capture the seed; LFSR=seed, or DEFAULT_SEED if seed==0. busy rises the next cycle. start in any other state is ignored.
- INIT (1 cycle):
  - deck[n] = {rank=(n%13)+1, suit=n/13, 1'b0} for n=0..51.
  - stock_pile and all tableaus cleared.
  - i=51 -> SHUFFLE.
- SHUFFLE, one LFSR step per cycle:
  - lfsr_next = (lfsr>>1) ^ (lfsr[0] ? LFSR_TAPS : 0); j = lfsr_next[5:0].
  - If j<=i: swap deck[i] and deck[j] (j==i is a no-op swap) and decrement i.
  - Otherwise reject and retry next cycle, with i unchanged.
  - When i reaches 0, go to DEAL.
  - Cycle count is seed-dependent but deterministic.
- DEAL: 28 cycles, deck pointer p=0..27, round r=0..6, pile t=r+1..7.
  - Each cycle writes deck[p] into tableau t, slot r.
  - Bit 0 is set only when t==r+1 (top card face-up); all others are face-down.
  - Increment order: t, then r at t==7 (t restarts at r+2); p always increments.
- STOCK: 24 cycles; stock_pile[k] = deck[28+k] face-down, k=0..23. -> DONE.
- DONE (1 cycle): done=1, busy=0 this cycle -> IDLE.
- Output deck holds shuffled face-down codes. All outputs remain stable in IDLE.
- Latency from accepted start to done = 1 (INIT) + S (shuffle cycles, at least 51) + 28 + 24 + 1.
- Reset mid-operation: immediate return to IDLE with all outputs zero; no partial layout is retained.
- Width rules: i and j are 6 bits; the j<=i compare is unsigned; the rank field never exceeds 13.

Decomposition:
- parameters.v holds:
  - suit codes CLUBS/SPADES/HEARTS/DIAMONDS;
  - CARD_W=7, FACE_UP bit index;
  - DECK_SIZE=52, TABLEAU_DEPTH=19, STOCK_DEPTH=24, TABLEAU_CARDS=28;
  - state encodings.
- One sub-module, card_lfsr:
  - inputs: clk, rst, load, load_value[15:0], step;
  - outputs: value and next_value, both [15:0];
  - implements the Galois step with LFSR_TAPS.
- Shuffle, deal, and stock counters stay in deal_shuffler.

Test Plan:
- Reset check: hold rst low mid-run, then release -> every output 0, busy=0, done=0; a start pulse in the cycle after release is accepted.
- Permutation check: seed=16'h1234 full run -> deck holds each of the 52 codes exactly once (ignoring bit 0); done pulses exactly once.
- Layout check (same run):
  - tableau t holds exactly t non-zero cards;
  - only slot t-1 has bit 0 set;
  - tableau1 slot0 = deck[0]|1; tableau7 slot6 = deck[27]|1; tableau2 slot0 = deck[1];
  - stock_pile[k] = deck[28+k] with bit 0 clear.
- Seed determinism: two runs with seed 16'h1234 give identical outputs and cycle counts; seed=0 gives results identical to seed=16'hACE1.
- Busy rule: a start pulse asserted mid-SHUFFLE is ignored. Layout and latency match an undisturbed run, and done pulses once.
- Latency accounting: count rejected draws in the bench model; measured start-to-done equals 1 + S + 28 + 24 + 1 exactly.
